// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: multiplier FSM states and datapath constants.
package riscv_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_ITERS = 32;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/add32.sv
// 32-bit ripple-style adder with carry-in and carry-out.
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_1,
    output logic [31:0] s,
    output logic        c31
);

    assign {c31, s} = {1'b0, a} + {1'b0, b} + {32'b0, c_1};

endmodule

// File: rtl/mul32_seq_ctrl.sv
// Sequential shift-add 32x32->64 unsigned multiplier, one add32 pass per cycle.
import riscv_pkg::*;

module mul32_seq_ctrl #(
    parameter bit ZERO_SKIP = 1'b1,
    parameter int CNT_W     = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] prod_hi,
    output logic [XLEN-1:0] prod_lo,
    output logic            busy
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

    mul_state_e      r_state;
    mul_state_e      w_next;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_acc_hi;
    logic [XLEN-1:0] r_acc_lo;
    logic [CNT_W-1:0] r_cnt;
    logic            r_out_valid;

    logic            w_accept;
    logic            w_opnd_zero;
    logic            w_take;
    logic [XLEN-1:0] w_sum;
    logic            w_c31;
    logic [XLEN-1:0] w_hi;
    logic            w_hi_c;

    assign w_accept    = in_valid & in_ready;
    assign w_opnd_zero = (a == '0) | (b == '0);
    assign w_take      = r_out_valid & out_ready;

    add32 u_add (
        .a   (r_acc_hi),
        .b   (r_mcand),
        .c_1 (1'b0),
        .s   (w_sum),
        .c31 (w_c31)
    );

    assign w_hi   = r_acc_lo[0] ? w_sum : r_acc_hi;
    assign w_hi_c = r_acc_lo[0] & w_c31;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= MUL_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            MUL_IDLE: if (w_accept) w_next = (ZERO_SKIP && w_opnd_zero) ? MUL_DONE : MUL_RUN;
            MUL_RUN:  if (r_cnt == LAST_ITER) w_next = MUL_DONE;
            MUL_DONE: if (w_take) w_next = MUL_IDLE;
            default:  w_next = MUL_IDLE;
        endcase
        if (flush) w_next = MUL_IDLE;
    end

    // out_valid is registered, so it rises one cycle after DONE is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            r_mcand     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
                        r_acc_lo <= (ZERO_SKIP && w_opnd_zero) ? '0 : b;
                    end
                end
                MUL_RUN: begin
                    {r_acc_hi, r_acc_lo} <= {w_hi_c, w_hi, r_acc_lo[XLEN-1:1]};
                    r_cnt                <= r_cnt + CNT_W'(1);
                end
                MUL_DONE: r_out_valid <= ~w_take;
                default:  r_out_valid <= 1'b0;
            endcase
        end
    end

    assign in_ready  = (r_state == MUL_IDLE);
    assign busy      = (r_state != MUL_IDLE);
    assign out_valid = r_out_valid;
    assign prod_hi   = r_acc_hi;
    assign prod_lo   = r_acc_lo;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// Self-checking bench for mul32_seq_ctrl: directed table, corner sequences, random ops.
module tb_mul32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        sel = 1'b0;   // 0: ZERO_SKIP=1 instance, 1: ZERO_SKIP=0 instance

    logic        rdy0, ov0, busy0, rdy1, ov1, busy1;
    logic [31:0] hi0, lo0, hi1, lo1;

    int n_vec = 0;
    int n_err = 0;
    logic watch = 1'b0;
    logic saw_valid = 1'b0;

    always #5 clk = ~clk;

    mul32_seq_ctrl #(.ZERO_SKIP(1'b1), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid & ~sel), .in_ready(rdy0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(out_ready),
        .prod_hi(hi0), .prod_lo(lo0), .busy(busy0)
    );

    mul32_seq_ctrl #(.ZERO_SKIP(1'b0), .CNT_W(6)) dut_nz (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid & sel), .in_ready(rdy1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready),
        .prod_hi(hi1), .prod_lo(lo1), .busy(busy1)
    );

    wire        m_rdy  = sel ? rdy1 : rdy0;
    wire        m_ov   = sel ? ov1 : ov0;
    wire        m_busy = sel ? busy1 : busy0;
    wire [63:0] m_prod = sel ? {hi1, lo1} : {hi0, lo0};

    always @(negedge clk) if (watch && (ov0 || ov1)) saw_valid = 1'b1;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [63:0] prod;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] xa, input logic [31:0] xb);
        @(negedge clk);
        check("in_ready_before_accept", {63'd0, m_rdy}, 64'd1);
        in_valid = 1'b1;
        a = xa;
        b = xb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (m_ov) break;
        end
    endtask

    task automatic finish_op;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_after_take", {62'd0, m_ov, m_rdy}, 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] xa, input logic [31:0] xb,
                          input logic xsel, input logic [63:0] exp_prod, input int exp_lat);
        int lat;
        sel = xsel;
        start_op(xa, xb);
        wait_valid(lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_product"}, m_prod, exp_prod);
        finish_op();
    endtask

    // Reference: the product is plain 64-bit arithmetic; zero-skip shortens latency.
    function automatic int ref_lat(input logic [31:0] xa, input logic [31:0] xb, input logic xsel);
        return (!xsel && (xa == 0 || xb == 0)) ? 1 : 33;
    endfunction

    initial begin
        vec_t vecs[$];
        logic [63:0] held;
        int lat;

        vecs.push_back('{"one_x_five", 32'd1, 32'd5, 1'b0, 64'd5, 33});
        vecs.push_back('{"max_x_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 33});
        vecs.push_back('{"big_pair", 32'd84762388, 32'd983453876, 1'b0, 64'd83359899017615888, 33});
        vecs.push_back('{"b2b_24x79", 32'd24, 32'd79, 1'b0, 64'd1896, 33});
        vecs.push_back('{"zskip_0x123", 32'd0, 32'd123, 1'b0, 64'd0, 1});
        vecs.push_back('{"nozskip_0x123", 32'd0, 32'd123, 1'b1, 64'd0, 33});
        vecs.push_back('{"zskip_b0", 32'hDEADBEEF, 32'd0, 1'b0, 64'd0, 1});

        #12;
        check("reset_in_ready", {63'd0, rdy0}, 64'd1);
        check("reset_out_valid_busy", {62'd0, ov0, busy0}, 64'd0);
        check("reset_prod", {hi0, lo0}, 64'd0);
        rst_n = 1'b1;
        a = 'x;
        b = 'x;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].prod, vecs[i].lat);

        // Result held in DONE while the consumer stalls; new operands ignored.
        sel = 1'b0;
        start_op(32'd1000, 32'd3000);
        wait_valid(lat);
        check("stall_latency", 64'(lat), 64'd33);
        held = m_prod;
        check("stall_product", held, 64'd3000000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            a = 32'h55 + i;
            b = 32'h77;
            @(posedge clk);
            #1;
            check("stall_hold", {m_prod[61:0], m_ov, m_rdy}, {held[61:0], 1'b1, 1'b0});
        end
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        finish_op();
        repeat (3) @(posedge clk);
        #1;
        check("no_queued_op", {63'd0, m_busy}, 64'd0);

        // Flush beats a simultaneous accept.
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        a = 32'd2;
        b = 32'd3;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        check("flush_vs_accept", {62'd0, m_busy, m_rdy}, 64'd1);

        // Abort by flush at cnt=10, then by reset at cnt=20; no result may appear.
        watch = 1'b1;
        start_op(32'd3, 32'd5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", {61'd0, m_ov, m_busy, m_rdy}, 64'd1);
        start_op(32'd9, 32'd9);
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_idle", {61'd0, m_ov, m_busy, m_rdy}, 64'd1);
        check("rst_prod", m_prod, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_valid", {63'd0, saw_valid}, 64'd0);
        watch = 1'b0;
        run_op("after_abort_7x6", 32'd7, 32'd6, 1'b0, 64'd42, 33);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            logic        rs;
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: rb = '0;
                2: ra = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op("rand", ra, rb, rs, 64'(ra) * 64'(rb), ref_lat(ra, rb, rs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
